// File: rtl/neopix_frame_scheduler.sv
// Round-robin scheduler sharing one WS2812 byte encoder between two SPI-fed
// pixel channels: streams the granted frame buffer, then holds the latch gap.
module neopix_frame_scheduler #(
    parameter int ADDR_W       = 8,
    parameter int LATCH_CYCLES = 2500
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        req_i,
    input  logic [ADDR_W:0]   len0_i,
    input  logic [ADDR_W:0]   len1_i,
    output logic [1:0]        ack_o,
    output logic              buf_sel_o,
    output logic [ADDR_W-1:0] buf_addr_o,
    input  logic [7:0]        buf_data_i,
    output logic              enc_valid_o,
    output logic [7:0]        enc_data_o,
    input  logic              enc_ready_i,
    input  logic              enc_idle_i,
    output logic              do_sel_o,
    output logic              busy_o
);

    localparam int CNT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [ADDR_W:0]  LEN_MAX  = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, SEND, DRAIN, LATCH, DONE} state_t;

    state_t            state, state_n;
    logic              last_grant, last_n;
    logic              chan, chan_n;
    logic [ADDR_W:0]   len_q, len_n;
    logic [ADDR_W:0]   idx, idx_n;
    logic [ADDR_W-1:0] addr_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [1:0]        ack_n;
    logic              vld_n;
    logic [7:0]        data_n;

    logic              pick;
    logic [ADDR_W:0]   len_pick;
    logic [ADDR_W:0]   len_sat;
    logic [ADDR_W:0]   idx_inc;

    // With both channels pending, the one not served last wins.
    assign pick     = (req_i == 2'b11) ? ~last_grant : req_i[1];
    assign len_pick = pick ? len1_i : len0_i;
    assign len_sat  = (len_pick > LEN_MAX) ? LEN_MAX : len_pick;
    assign idx_inc  = idx + (ADDR_W+1)'(1);

    assign buf_sel_o = chan;
    assign do_sel_o  = chan;
    assign busy_o    = (state != IDLE);

    always_comb begin
        state_n = state;
        last_n  = last_grant;
        chan_n  = chan;
        len_n   = len_q;
        idx_n   = idx;
        addr_n  = buf_addr_o;
        cnt_n   = cnt;
        ack_n   = 2'b00;
        vld_n   = enc_valid_o;
        data_n  = enc_data_o;
        case (state)
            IDLE: begin
                if (|req_i) begin
                    last_n  = pick;
                    chan_n  = pick;
                    len_n   = len_sat;
                    idx_n   = '0;
                    addr_n  = '0;
                    cnt_n   = '0;
                    state_n = (len_sat == '0) ? LATCH : FETCH;
                end
            end
            FETCH: state_n = LOAD;
            LOAD: begin
                data_n  = buf_data_i;
                vld_n   = 1'b1;
                state_n = SEND;
            end
            SEND: begin
                if (enc_ready_i) begin
                    vld_n = 1'b0;
                    idx_n = idx_inc;
                    // Address is only advanced when another byte follows,
                    // so it never points past the end of the frame.
                    if (idx_inc == len_q) begin
                        state_n = DRAIN;
                    end else begin
                        addr_n  = idx_inc[ADDR_W-1:0];
                        state_n = FETCH;
                    end
                end
            end
            DRAIN: begin
                if (enc_idle_i) begin
                    cnt_n   = '0;
                    state_n = LATCH;
                end
            end
            LATCH: begin
                if (cnt == CNT_LAST) begin
                    ack_n   = chan ? 2'b10 : 2'b01;
                    state_n = DONE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            chan        <= 1'b0;
            len_q       <= '0;
            idx         <= '0;
            buf_addr_o  <= '0;
            cnt         <= '0;
            ack_o       <= 2'b00;
            enc_valid_o <= 1'b0;
            enc_data_o  <= 8'h00;
        end else begin
            state       <= state_n;
            last_grant  <= last_n;
            chan        <= chan_n;
            len_q       <= len_n;
            idx         <= idx_n;
            buf_addr_o  <= addr_n;
            cnt         <= cnt_n;
            ack_o       <= ack_n;
            enc_valid_o <= vld_n;
            enc_data_o  <= data_n;
        end
    end

endmodule
